pattern_event_logger: RTL and testbench

- Downstream consumer of the serial pattern detector's 2-bit event code.
- Samples the code every clock and keeps saturating per-pattern counters.
- Timestamps each event and buffers it in a small FIFO.
- Software/test logic drains events through a valid/ready read port.

---
 rtl/pattern_pkg.sv | 18 +
 rtl/pattern_event_logger_if.sv | 16 +
 rtl/pattern_event_logger_sync_fifo.sv | 57 +++++
 rtl/pattern_event_logger.sv | 105 ++++++++++
 tb/tb_pattern_event_logger.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_pkg.sv
// Event codes shared by the serial pattern detector, the event logger and their benches.
package pattern_pkg;

  localparam int unsigned CODE_W = 2;

  typedef enum logic [CODE_W-1:0] {
    PAT_NONE    = 2'b00,
    PAT_101     = 2'b01,
    PAT_010     = 2'b10,
    PAT_ILLEGAL = 2'b11
  } pat_e;

  // Only the two real detections are logged and counted.
  function automatic logic is_event(input logic [CODE_W-1:0] code);
    return (code == PAT_101) || (code == PAT_010);
  endfunction

endpackage

// File: rtl/pattern_event_logger_if.sv
// Show-ahead valid/ready read port of the pattern event logger.
interface pattern_event_logger_if #(
  parameter int unsigned TS_W = 8
);
  import pattern_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [CODE_W-1:0] rd_code;
  logic [TS_W-1:0]   rd_ts;

  // Logger side drives the head entry, consumer side returns ready.
  modport master (output rd_valid, output rd_code, output rd_ts, input rd_ready);
  modport slave  (input rd_valid, input rd_code, input rd_ts, output rd_ready);

endinterface

// File: rtl/pattern_event_logger_sync_fifo.sv
// Small show-ahead synchronous FIFO; rdata reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pattern_event_logger.sv
// Counts, timestamps and buffers detector events for a valid/ready consumer.
// Build option: PLOG_TIMESTAMP_EN adds the free-running timestamp to each entry.
module pattern_event_logger
  import pattern_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TS_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CODE_W-1:0]      det_i,
  input  logic                   clear,
  pattern_event_logger_if.master rd,
  output logic [CNT_W-1:0]       cnt_101,
  output logic [CNT_W-1:0]       cnt_010,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   illegal
);

`ifdef PLOG_TIMESTAMP_EN
  localparam int unsigned FW = CODE_W + TS_W;
`else
  localparam int unsigned FW = CODE_W;
`endif

  logic          evt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;

  assign evt  = is_event(det_i);
  assign pop  = !fifo_empty && rd.rd_ready;
  assign push = evt && (!fifo_full || pop);
  // Counters still advance on a drop: they count detections, not stored entries.
  assign drop = evt && fifo_full && !pop;

`ifdef PLOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running stamp; clear deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  assign wdata      = {det_i, ts};
  assign rd.rd_code = rdata[FW-1 -: CODE_W];
  assign rd.rd_ts   = rdata[TS_W-1:0];
`else
  assign wdata      = det_i;
  assign rd.rd_code = rdata;
  assign rd.rd_ts   = TS_W'(0);
`endif

  assign rd.rd_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Saturating detection counters and sticky status flags.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_101  <= '0;
      cnt_010  <= '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if ((det_i == PAT_101) && (cnt_101 != '1)) begin
        cnt_101 <= cnt_101 + CNT_W'(1);
      end
      if ((det_i == PAT_010) && (cnt_010 != '1)) begin
        cnt_010 <= cnt_010 + CNT_W'(1);
      end
      if (det_i == PAT_ILLEGAL) begin
        illegal <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed plus randomized bench for pattern_event_logger against a queue-based reference.
module tb_pattern_event_logger;
  import pattern_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TS_MOD  = 1 << TS_W;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [1:0]             det_i = 2'b00;
  logic                   clear = 1'b0;
  logic [CNT_W-1:0]       cnt_101;
  logic [CNT_W-1:0]       cnt_010;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   illegal;

  pattern_event_logger_if #(.TS_W(TS_W)) rd_if ();

  pattern_event_logger #(
    .CNT_W (CNT_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .det_i    (det_i),
    .clear    (clear),
    .rd       (rd_if.master),
    .cnt_101  (cnt_101),
    .cnt_010  (cnt_010),
    .level    (level),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  // Reference state: buffered entries as {code, stamp}, counts, flags, current stamp.
  typedef struct {
    int code;
    int ts;
  } entry_t;

  entry_t q[$];
  int     m_ts;
  int     m_c101;
  int     m_c010;
  int     m_ovf;
  int     m_ill;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic model_edge();
    int stamp;
    entry_t e;
    if (reset) begin
      q.delete();
      m_c101 = 0; m_c010 = 0; m_ovf = 0; m_ill = 0; m_ts = 0;
    end else begin
      stamp = m_ts;
      m_ts  = (m_ts + 1) % TS_MOD;
      if (clear) begin
        q.delete();
        m_c101 = 0; m_c010 = 0; m_ovf = 0; m_ill = 0;
      end else begin
        if (q.size() > 0 && rd_if.rd_ready) void'(q.pop_front());
        if (det_i == 2'b11) m_ill = 1;
        if (det_i == 2'b01 || det_i == 2'b10) begin
          if (det_i == 2'b01) m_c101 = (m_c101 < CNT_MAX) ? m_c101 + 1 : CNT_MAX;
          else                m_c010 = (m_c010 < CNT_MAX) ? m_c010 + 1 : CNT_MAX;
          if (q.size() < DEPTH) begin
            e.code = int'(det_i);
            e.ts   = stamp;
            q.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_code;
    int exp_ts;
    exp_code = (q.size() > 0) ? q[0].code : 0;
`ifdef PLOG_TIMESTAMP_EN
    exp_ts = (q.size() > 0) ? q[0].ts : 0;
`else
    exp_ts = 0;
`endif
    chk({tag, ".rd_valid"}, int'(rd_if.rd_valid), (q.size() > 0) ? 1 : 0);
    chk({tag, ".rd_code"},  int'(rd_if.rd_code), exp_code);
    chk({tag, ".rd_ts"},    int'(rd_if.rd_ts), exp_ts);
    chk({tag, ".cnt_101"},  int'(cnt_101), m_c101);
    chk({tag, ".cnt_010"},  int'(cnt_010), m_c010);
    chk({tag, ".level"},    int'(level), q.size());
    chk({tag, ".overflow"}, int'(overflow), m_ovf);
    chk({tag, ".illegal"},  int'(illegal), m_ill);
  endtask

  // One clock: reference follows the sampled inputs, outputs checked 1ns after the edge.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] d, input logic rdy, input logic clr);
    det_i          = d;
    rd_if.rd_ready = rdy;
    clear          = clr;
  endtask

  initial begin
    int exp_ts5;
    rd_if.rd_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    step("reset0");
    step("reset1");
    reset = 1'b0;
    chk("reset.level", int'(level), 0);
    chk("reset.rd_ts", int'(rd_if.rd_ts), 0);

    // First event lands in the head one edge later with the pre-edge stamp
    drive(2'b00, 1'b0, 1'b0);
    repeat (5) step("idle");
    drive(2'b01, 1'b0, 1'b0);
    step("first_evt");
`ifdef PLOG_TIMESTAMP_EN
    exp_ts5 = 5;
`else
    exp_ts5 = 0;
`endif
    chk("first_evt.ts_const", int'(rd_if.rd_ts), exp_ts5);
    chk("first_evt.code_const", int'(rd_if.rd_code), 1);
    chk("first_evt.level_const", int'(level), 1);

    // Fill past full: fifth event is dropped but still counted
    drive(2'b00, 1'b0, 1'b1);
    step("clear_a");
    drive(2'b01, 1'b0, 1'b0); step("fill0");
    drive(2'b10, 1'b0, 1'b0); step("fill1");
    drive(2'b01, 1'b0, 1'b0); step("fill2");
    drive(2'b10, 1'b0, 1'b0); step("fill3");
    drive(2'b01, 1'b0, 1'b0); step("fill4");
    chk("full.level_const", int'(level), 4);
    chk("full.overflow_const", int'(overflow), 1);
    chk("full.cnt101_const", int'(cnt_101), 3);
    chk("full.cnt010_const", int'(cnt_010), 2);
    drive(2'b00, 1'b1, 1'b0);
    repeat (4) step("drain");
    chk("drain.valid_const", int'(rd_if.rd_valid), 0);

    // Full with simultaneous pop and push
    drive(2'b00, 1'b0, 1'b1);
    step("clear_b");
    drive(2'b01, 1'b0, 1'b0);
    repeat (4) step("refill");
    drive(2'b10, 1'b1, 1'b0);
    step("full_pushpop");
    chk("pushpop.level_const", int'(level), 4);
    chk("pushpop.overflow_const", int'(overflow), 0);
    drive(2'b00, 1'b1, 1'b0);
    repeat (3) step("drain_b");
    chk("pushpop.tail_const", int'(rd_if.rd_code), 2);
    step("drain_b_last");

    // Counter saturation with continuous draining
    drive(2'b00, 1'b0, 1'b1);
    step("clear_c");
    drive(2'b01, 1'b1, 1'b0);
    repeat (260) step("sat");
    chk("sat.cnt101_const", int'(cnt_101), 255);

    // Illegal code, then clear beating a concurrent event
    drive(2'b11, 1'b0, 1'b0);
    step("illegal");
    chk("illegal.flag_const", int'(illegal), 1);
    drive(2'b01, 1'b0, 1'b1);
    step("clear_evt");
    chk("clear_evt.level_const", int'(level), 0);
    chk("clear_evt.cnt101_const", int'(cnt_101), 0);
    chk("clear_evt.illegal_const", int'(illegal), 0);

    // Reset mid-stream with entries buffered near stamp 200
    drive(2'b10, 1'b0, 1'b0);
    repeat (3) step("buf3");
    drive(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 2 * TS_MOD && m_ts != 200; i++) step("wait_ts");
    chk("pre_reset.ts_reached", m_ts, 200);
    chk("pre_reset.level_const", int'(level), 3);
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    chk("mid_reset.valid_const", int'(rd_if.rd_valid), 0);
    drive(2'b01, 1'b0, 1'b0);
    step("post_reset_evt");
    chk("post_reset.ts_const", int'(rd_if.rd_ts), 0);

    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 8)       det_i = 2'b00;
      else if (r < 13) det_i = 2'b01;
      else if (r < 18) det_i = 2'b10;
      else             det_i = 2'b11;
      rd_if.rd_ready = ($urandom_range(0, 2) == 0);
      clear          = ($urandom_range(0, 149) == 0);
      reset          = ($urandom_range(0, 399) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
